// File: rtl/slice_fcarry_cfg.sv
// Logic slice with fracturable LUTs, a ripple carry chain and a serial configuration loader.
// Configuration is shifted into a shadow register and copied to the active register in one commit.
//
//   state     | meaning
//   ST_IDLE   | no load in progress; the first cfg_en bit starts a load
//   ST_LOAD   | shifting stream bits into the shadow register
//   ST_COMMIT | shadow copied to active, cfg_done raised on the same edge
module slice_fcarry_cfg #(
    parameter int LUT_INPUTS = 4,
    parameter int NUM_LUTS   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_en,
    input  logic                             cfg_in,
    input  logic                             cfg_abort,
    output logic                             cfg_out,
    output logic                             cfg_busy,
    output logic                             cfg_done,
    input  logic [NUM_LUTS*LUT_INPUTS-1:0]   lut_in,
    input  logic                             ci,
    input  logic                             reg_ce,
    output logic                             co,
    output logic [2*NUM_LUTS-1:0]            out
);
    localparam int K        = LUT_INPUTS;
    localparam int TT       = 2**K;
    localparam int FW       = TT + 1;
    localparam int RM_LSB   = NUM_LUTS*FW;
    localparam int CFG_BITS = NUM_LUTS*FW + NUM_LUTS + 1;
    localparam int CW       = $clog2(CFG_BITS+1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CFG_BITS-1:0]   shadow_q, shadow_d;
    logic [CFG_BITS-1:0]   active_q, active_d;
    logic                  done_q, done_d;
    logic [2*NUM_LUTS-1:0] oreg_q;
    logic [2*NUM_LUTS-1:0] comb_out;
    logic [NUM_LUTS:0]     carry;
    logic [NUM_LUTS-1:0]   reg_mode;
    logic                  use_cc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_en) begin
                    shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
                    cnt_d    = CW'(1);
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // abort wins over a simultaneous shift
                if (cfg_abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cfg_en) begin
                    shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(CFG_BITS-1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                active_d = shadow_q;
                done_d   = 1'b1;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // output flops are independent of commits; only reg_ce moves them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_q <= '0;
        end else if (reg_ce) begin
            oreg_q <= comb_out;
        end
    end

    assign reg_mode = active_q[RM_LSB +: NUM_LUTS];
    assign use_cc   = active_q[CFG_BITS-1];
    assign carry[0] = ci;

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        logic [K-1:0]  addr;
        logic [TT-1:0] tt;
        logic          frac;
        logic          hi_bit;
        logic          lo_bit;
        logic          a_bit;
        logic          b_bit;

        assign addr   = lut_in[K*i +: K];
        assign tt     = active_q[FW*i +: TT];
        assign frac   = active_q[FW*i + TT];
        assign hi_bit = tt[{1'b1, addr[K-2:0]}];
        assign lo_bit = tt[{1'b0, addr[K-2:0]}];
        // lower half-LUT is propagate, upper half is generate
        assign carry[i+1] = lo_bit ? carry[i] : hi_bit;

        always_comb begin
            a_bit = tt[addr];
            b_bit = tt[addr];
            if (use_cc) begin
                a_bit = lo_bit ^ carry[i];
                b_bit = lo_bit;
            end else if (frac) begin
                a_bit = hi_bit;
                b_bit = lo_bit;
            end
        end

        assign comb_out[2*i +: 2] = {b_bit, a_bit};
        assign out[2*i +: 2]      = reg_mode[i] ? oreg_q[2*i +: 2] : {b_bit, a_bit};
    end

    assign co       = use_cc ? carry[NUM_LUTS] : ci;
    assign cfg_out  = shadow_q[0];
    assign cfg_busy = (state_q != ST_IDLE);
    assign cfg_done = done_q;

endmodule

// File: tb/tb_slice_fcarry_cfg.sv
// Self-checking bench for slice_fcarry_cfg at K=4, NUM_LUTS=4 (73-bit stream),
// compared against a behavioural model of the active configuration.
module tb_slice_fcarry_cfg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_in = 1'b0;
    logic        cfg_abort = 1'b0;
    logic        ci = 1'b0;
    logic        reg_ce = 1'b0;
    logic [15:0] lut_in = '0;
    logic        cfg_out, cfg_busy, cfg_done, co;
    logic [7:0]  out;

    int          checks = 0;
    int          errors = 0;
    logic [72:0] m_act = '0;
    logic [7:0]  m_reg = '0;

    always #5 clk = ~clk;

    slice_fcarry_cfg #(.LUT_INPUTS(4), .NUM_LUTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_abort(cfg_abort),
        .cfg_out(cfg_out), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .lut_in(lut_in), .ci(ci), .reg_ce(reg_ce), .co(co), .out(out)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural slice: truth-table lookup, half-LUT split, ripple add
    function automatic void model(input logic [72:0] c, input logic [15:0] lin, input logic cin,
                                  output logic [7:0] o, output logic cout);
        logic [15:0] t;
        int          a, lo;
        logic        h, l, cy;
        cy = cin;
        o  = '0;
        for (int i = 0; i < 4; i++) begin
            t  = c[17*i +: 16];
            a  = int'((lin >> (4*i)) & 16'hF);
            lo = a % 8;
            h  = t[lo+8];
            l  = t[lo];
            if (c[72]) begin
                o[2*i]   = l ^ cy;
                o[2*i+1] = l;
                cy       = l ? cy : h;
            end else if (c[17*i+16]) begin
                o[2*i]   = h;
                o[2*i+1] = l;
            end else begin
                o[2*i]   = t[a];
                o[2*i+1] = t[a];
            end
        end
        cout = c[72] ? cy : cin;
    endfunction

    function automatic logic [7:0] exp_out();
        logic [7:0] o;
        logic       c;
        model(m_act, lut_in, ci, o, c);
        for (int i = 0; i < 4; i++)
            if (m_act[68+i]) o[2*i +: 2] = m_reg[2*i +: 2];
        return o;
    endfunction

    function automatic logic exp_co();
        logic [7:0] o;
        logic       c;
        model(m_act, lut_in, ci, o, c);
        return c;
    endfunction

    function automatic logic [72:0] mk(input logic [63:0] tts, input logic [3:0] frac,
                                       input logic [3:0] rm, input logic cc);
        logic [72:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c[17*i +: 16] = tts[16*i +: 16];
            c[17*i+16]    = frac[i];
        end
        c[71:68] = rm;
        c[72]    = cc;
        return c;
    endfunction

    function automatic logic [72:0] rnd73();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[72:0];
    endfunction

    task automatic tick();
        logic [7:0] o;
        logic       c;
        model(m_act, lut_in, ci, o, c);
        if (reg_ce) m_reg = o;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_inputs();
        lut_in = 16'($urandom);
        ci     = 1'($urandom);
    endtask

    task automatic load_cfg(input logic [72:0] c, input int gap_at);
        for (int n = 0; n < 73; n++) begin
            if (n == gap_at) begin
                cfg_en = 1'b0;
                repeat (5) tick();
                checks++;
                if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
                    errors++;
                    $display("FAIL load_gap busy/done got %b%b exp 10", cfg_busy, cfg_done);
                end
            end
            cfg_en = 1'b1;
            cfg_in = c[n];
            tick();
        end
        cfg_en = 1'b0;
        checks++;
        if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL load_commit_state busy/done got %b%b exp 10", cfg_busy, cfg_done);
        end
        tick();
        m_act = c;
        checks++;
        if (cfg_done !== 1'b1 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse done/busy got %b%b exp 10", cfg_done, cfg_busy);
        end
        tick();
        checks++;
        if (cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_width done got %b exp 0", cfg_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int v = 0; v < 2; v++) begin
            ci = 1'(v);
            #1;
            checks++;
            if (out !== 8'h00 || co !== ci || cfg_busy !== 1'b0 || cfg_done !== 1'b0 || cfg_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got out=%h co=%b busy=%b done=%b cfg_out=%b exp out=00 co=%b 0 0 0",
                         out, co, cfg_busy, cfg_done, cfg_out, ci);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midload();
        load_cfg(mk(64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 4'h0, 1'b0), -1);
        for (int n = 0; n < 30; n++) begin
            cfg_en = 1'b1;
            cfg_in = 1'($urandom);
            tick();
        end
        checks++;
        if (cfg_busy !== 1'b1) begin
            errors++;
            $display("FAIL midload_busy got %b exp 1", cfg_busy);
        end
        #2;
        rst_n  = 1'b0;
        cfg_en = 1'b0;
        ci     = 1'($urandom);
        m_act  = '0;
        m_reg  = '0;
        #1;
        checks++;
        if (cfg_busy !== 1'b0 || out !== 8'h00 || co !== ci) begin
            errors++;
            $display("FAIL midload_reset got busy=%b out=%h co=%b exp 0 00 %b", cfg_busy, out, co, ci);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load_cfg(rnd73(), -1);
        for (int k = 0; k < 4; k++) begin
            rnd_inputs();
            #1;
            checks++;
            if (out !== exp_out() || co !== exp_co()) begin
                errors++;
                $display("FAIL postreset_func got out=%h co=%b exp %h %b", out, co, exp_out(), exp_co());
            end
        end
    endtask

    task automatic test_and_lut();
        load_cfg(mk(64'h0000_0000_0000_8000, 4'h0, 4'h0, 1'b0), -1);
        lut_in = {12'($urandom), 4'hF};
        #1;
        checks++;
        if (out[1:0] !== 2'b11 || out !== exp_out()) begin
            errors++;
            $display("FAIL and_lut_F got %h exp lsb 11 full %h", out, exp_out());
        end
        lut_in = {12'($urandom), 4'hE};
        #1;
        checks++;
        if (out[1:0] !== 2'b00 || out !== exp_out()) begin
            errors++;
            $display("FAIL and_lut_E got %h exp lsb 00 full %h", out, exp_out());
        end
    endtask

    task automatic test_carry();
        logic [3:0] a, b;
        logic [4:0] sum;
        load_cfg(mk({4{16'h8866}}, 4'h0, 4'h0, 1'b1), -1);
        a = 4'hB; b = 4'h6; ci = 1'b1;
        for (int i = 0; i < 4; i++) lut_in[4*i +: 4] = {2'b00, b[i], a[i]};
        #1;
        checks++;
        if ({out[6], out[4], out[2], out[0]} !== 4'b0010 || co !== 1'b1) begin
            errors++;
            $display("FAIL carry_fixed got A=%b co=%b exp 0010 1", {out[6], out[4], out[2], out[0]}, co);
        end
        for (int k = 0; k < 10; k++) begin
            a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
            for (int i = 0; i < 4; i++) lut_in[4*i +: 4] = {1'($urandom), 1'b0, b[i], a[i]};
            sum = 5'(a) + 5'(b) + 5'(ci);
            #1;
            checks++;
            if ({out[6], out[4], out[2], out[0]} !== sum[3:0] || co !== sum[4] || out !== exp_out()) begin
                errors++;
                $display("FAIL carry_rand a=%h b=%h ci=%b got out=%h co=%b exp sum=%h out=%h",
                         a, b, ci, out, co, sum, exp_out());
            end
        end
    endtask

    task automatic test_reg_mode();
        logic [72:0] c;
        logic [7:0]  held, o;
        logic        cy;
        c = rnd73();
        c[71:68] = 4'hF;
        load_cfg(c, -1);
        reg_ce = 1'b1;
        rnd_inputs();
        tick();
        reg_ce = 1'b0;
        held = out;
        checks++;
        if (out !== m_reg) begin
            errors++;
            $display("FAIL reg_first_load got %h exp %h", out, m_reg);
        end
        for (int k = 0; k < 5; k++) begin
            rnd_inputs();
            tick();
            checks++;
            if (out !== held) begin
                errors++;
                $display("FAIL reg_hold got %h exp %h", out, held);
            end
        end
        rnd_inputs();
        reg_ce = 1'b1;
        model(m_act, lut_in, ci, o, cy);
        tick();
        reg_ce = 1'b0;
        checks++;
        if (out !== o) begin
            errors++;
            $display("FAIL reg_update got %h exp %h", out, o);
        end
        held = out;
        c = rnd73();
        c[71:68] = 4'hF;
        load_cfg(c, -1);
        checks++;
        if (out !== held) begin
            errors++;
            $display("FAIL reg_commit_keeps got %h exp %h", out, held);
        end
    endtask

    task automatic test_abort();
        logic [72:0] c;
        c = rnd73();
        c[71:68] = 4'h0;
        load_cfg(c, -1);
        for (int n = 0; n < 40; n++) begin
            cfg_en = 1'b1;
            cfg_in = 1'($urandom);
            tick();
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_en = 1'b0;
        checks++;
        if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy/done got %b%b exp 00", cfg_busy, cfg_done);
        end
        for (int k = 0; k < 4; k++) begin
            rnd_inputs();
            tick();
            checks++;
            if (cfg_done !== 1'b0 || out !== exp_out() || co !== exp_co()) begin
                errors++;
                $display("FAIL abort_keep got done=%b out=%h co=%b exp 0 %h %b", cfg_done, out, co, exp_out(), exp_co());
            end
        end
        c = rnd73();
        c[71:68] = 4'h0;
        load_cfg(c, 30);
        rnd_inputs();
        #1;
        checks++;
        if (out !== exp_out() || co !== exp_co()) begin
            errors++;
            $display("FAIL gap_load_func got out=%h co=%b exp %h %b", out, co, exp_out(), exp_co());
        end
    endtask

    task automatic test_daisy();
        logic [145:0] s;
        s = {rnd73(), rnd73()};
        for (int n = 1; n <= 146; n++) begin
            cfg_en = 1'b1;
            cfg_in = s[n-1];
            #1;
            if (n >= 74) begin
                checks++;
                if (cfg_out !== s[n-74]) begin
                    errors++;
                    $display("FAIL daisy_bit n=%0d got %b exp %b", n, cfg_out, s[n-74]);
                end
            end
            tick();
            if (n == 73 || n == 146) begin
                cfg_en = 1'b0;
                tick();
                m_act = (n == 73) ? s[72:0] : s[145:73];
            end
        end
        rnd_inputs();
        #1;
        checks++;
        if (out !== exp_out() || co !== exp_co()) begin
            errors++;
            $display("FAIL daisy_active got out=%h co=%b exp %h %b", out, co, exp_out(), exp_co());
        end
    endtask

    initial begin
        test_reset();
        test_reset_midload();
        test_and_lut();
        test_carry();
        test_reg_mode();
        test_abort();
        test_daisy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
